// File: rtl/mem_rsp_pkg.sv
// mem_rsp_pkg: default sizing and entry layout for the RAM response FIFO.
// Build option: MEM_RSP_PARITY_EN adds an even-parity bit to every entry.
package mem_rsp_pkg;

  localparam int MEM_RSP_DATA_WIDTH = 32;
  localparam int MEM_RSP_FIFO_DEPTH = 8;

`ifdef MEM_RSP_PARITY_EN
  localparam int MEM_RSP_PAR_W = 1;

  typedef struct packed {
    logic                          parity;
    logic [MEM_RSP_DATA_WIDTH-1:0] data;
  } mem_rsp_entry_t;
`else
  localparam int MEM_RSP_PAR_W = 0;

  typedef struct packed {
    logic [MEM_RSP_DATA_WIDTH-1:0] data;
  } mem_rsp_entry_t;
`endif

endpackage

// File: rtl/mem_rsp_storage.sv
// mem_rsp_storage: entry register array, one write port and one
// combinational read port. Contents are deliberately not reset.
module mem_rsp_storage
  import mem_rsp_pkg::*;
#(
  parameter int  WIDTH = MEM_RSP_DATA_WIDTH + MEM_RSP_PAR_W,
  parameter int  DEPTH = MEM_RSP_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: first-word-fall-through buffer for RAM read responses.
// The RAM cannot be stalled, so a word arriving while full is dropped and
// flagged in the sticky Overflow bit.
// Build option: MEM_RSP_PARITY_EN stores even parity per entry and adds
// the Rsp_parity output.
module mem_rsp_fifo
  import mem_rsp_pkg::*;
#(
  parameter int  DATA_WIDTH = MEM_RSP_DATA_WIDTH,
  parameter int  FIFO_DEPTH = MEM_RSP_FIFO_DEPTH,
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_valid,
  input  logic [DATA_WIDTH-1:0] Mem_data,
  output logic                  Rsp_valid,
  input  logic                  Rsp_ready,
  output logic [DATA_WIDTH-1:0] Rsp_data,
`ifdef MEM_RSP_PARITY_EN
  output logic                  Rsp_parity,
`endif
  output logic [CNT_WIDTH-1:0]  Count,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Overflow,
  input  logic                  Clr_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef MEM_RSP_PARITY_EN
  localparam int ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 full, empty;
  logic                 push, pop, drop;
  logic [ENTRY_W-1:0]   wdata, rdata;

  // Flags come from the registered count only.
  assign full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = ~empty & Rsp_ready;
  assign push = Mem_valid & (~full | pop);
  assign drop = Mem_valid & ~push;

`ifdef MEM_RSP_PARITY_EN
  assign wdata = {^Mem_data, Mem_data};
`else
  assign wdata = Mem_data;
`endif

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (Clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  mem_rsp_storage #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  assign Rsp_valid = ~empty;
  assign Rsp_data  = empty ? '0 : rdata[DATA_WIDTH-1:0];
`ifdef MEM_RSP_PARITY_EN
  assign Rsp_parity = ~empty & rdata[DATA_WIDTH];
`endif
  assign Count    = count_q;
  assign Full     = full;
  assign Empty    = empty;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_mem_rsp_fifo.sv
// tb_mem_rsp_fifo: directed scenarios plus randomized traffic against a
// queue-based model of the response FIFO.
module tb_mem_rsp_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Mem_valid = 1'b0;
  logic [DW-1:0] Mem_data = '0;
  logic          Rsp_valid;
  logic          Rsp_ready = 1'b0;
  logic [DW-1:0] Rsp_data;
`ifdef MEM_RSP_PARITY_EN
  logic          Rsp_parity;
`endif
  logic [3:0]    Count;
  logic          Full;
  logic          Empty;
  logic          Overflow;
  logic          Clr_ovf = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] mq[$];
  bit            movf = 1'b0;

  always #5 clk = ~clk;

  mem_rsp_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .Mem_valid  (Mem_valid),
    .Mem_data   (Mem_data),
    .Rsp_valid  (Rsp_valid),
    .Rsp_ready  (Rsp_ready),
    .Rsp_data   (Rsp_data),
`ifdef MEM_RSP_PARITY_EN
    .Rsp_parity (Rsp_parity),
`endif
    .Count      (Count),
    .Full       (Full),
    .Empty      (Empty),
    .Overflow   (Overflow),
    .Clr_ovf    (Clr_ovf)
  );

  // One clock of stimulus; the model decides pop/push/drop from the rules,
  // and the word seen on Rsp_data before the edge is returned when a pop happens.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy, input bit clr,
                      output bit popped, output logic [DW-1:0] obs, output logic [DW-1:0] expw);
    bit p, u, dr;
    Mem_valid = v; Mem_data = d; Rsp_ready = rdy; Clr_ovf = clr;
    #1;
    p  = (mq.size() > 0) && rdy;
    u  = v && ((mq.size() < DEPTH) || p);
    dr = v && !u;
    popped = p;
    obs    = Rsp_data;
    expw   = p ? mq[0] : '0;
    @(posedge clk); #1;
    if (p) void'(mq.pop_front());
    if (u) mq.push_back(d);
    if (dr) movf = 1'b1;
    else if (clr) movf = 1'b0;
    Mem_valid = 1'b0; Rsp_ready = 1'b0; Clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    bit pp; logic [DW-1:0] o, e;
    #2;
    total_cnt++; if (Rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", Rsp_valid); else pass_cnt++;
    total_cnt++; if (Rsp_data !== '0) $display("FAIL reset_data got=%h exp=0", Rsp_data); else pass_cnt++;
    total_cnt++; if (Count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", Count); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1 || Full !== 1'b0) $display("FAIL reset_flags empty=%b full=%b exp 1/0", Empty, Full); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", Overflow); else pass_cnt++;
`ifdef MEM_RSP_PARITY_EN
    total_cnt++; if (Rsp_parity !== 1'b0) $display("FAIL reset_parity got=%b exp=0", Rsp_parity); else pass_cnt++;
`endif
    #10 rst = 1'b1;
    @(posedge clk); #1;
    step(0, '0, 0, 0, pp, o, e);
    step(0, '0, 0, 0, pp, o, e);
    total_cnt++; if (Empty !== 1'b1 || Count !== 4'd0) $display("FAIL idle_empty empty=%b count=%0d exp 1/0", Empty, Count); else pass_cnt++;
  endtask

  task automatic test_single();
    bit pp; logic [DW-1:0] o, e;
    step(1, 32'hDEAD_BEEF, 0, 0, pp, o, e);
    total_cnt++; if (Rsp_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", Rsp_valid); else pass_cnt++;
    total_cnt++; if (Rsp_data !== 32'hDEAD_BEEF) $display("FAIL single_data got=%h exp=deadbeef", Rsp_data); else pass_cnt++;
    total_cnt++; if (Count !== 4'd1) $display("FAIL single_count got=%0d exp=1", Count); else pass_cnt++;
    step(0, '0, 1, 0, pp, o, e);
    total_cnt++; if (!pp || o !== 32'hDEAD_BEEF) $display("FAIL single_pop popped=%b got=%h exp=deadbeef", pp, o); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL single_empty got=%b exp=1", Empty); else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    bit pp; logic [DW-1:0] o, e;
    for (int i = 1; i <= 9; i++) step(1, DW'(i), 0, 0, pp, o, e);
    total_cnt++; if (Full !== 1'b1) $display("FAIL fill_full got=%b exp=1", Full); else pass_cnt++;
    total_cnt++; if (Count !== 4'd8) $display("FAIL fill_count got=%0d exp=8", Count); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b1) $display("FAIL fill_ovf got=%b exp=1", Overflow); else pass_cnt++;
    for (int i = 1; i <= 8; i++) begin
      step(0, '0, 1, 0, pp, o, e);
      total_cnt++; if (!pp || o !== DW'(i)) $display("FAIL drain_word popped=%b got=%h exp=%h", pp, o, DW'(i)); else pass_cnt++;
    end
    total_cnt++; if (Empty !== 1'b1 || Rsp_valid !== 1'b0) $display("FAIL drain_no_word9 empty=%b valid=%b exp 1/0", Empty, Rsp_valid); else pass_cnt++;
    step(0, '0, 0, 1, pp, o, e);
    total_cnt++; if (Overflow !== 1'b0) $display("FAIL clr_ovf got=%b exp=0", Overflow); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    bit pp; logic [DW-1:0] o, e;
    for (int i = 0; i < 8; i++) step(1, DW'(32'h10 + i), 0, 0, pp, o, e);
    step(1, 32'hA5, 1, 0, pp, o, e);
    total_cnt++; if (!pp || o !== 32'h10) $display("FAIL fpp_pop popped=%b got=%h exp=10", pp, o); else pass_cnt++;
    total_cnt++; if (Count !== 4'd8) $display("FAIL fpp_count got=%0d exp=8", Count); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b0) $display("FAIL fpp_ovf got=%b exp=0", Overflow); else pass_cnt++;
    // drop and clear together: set wins
    step(1, 32'hFF, 0, 1, pp, o, e);
    total_cnt++; if (Overflow !== 1'b1 || Count !== 4'd8) $display("FAIL drop_clr ovf=%b count=%0d exp 1/8", Overflow, Count); else pass_cnt++;
    step(0, '0, 0, 1, pp, o, e);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 0, pp, o, e);
      total_cnt++; if (!pp || o !== e) $display("FAIL fpp_drain popped=%b got=%h exp=%h", pp, o, e); else pass_cnt++;
    end
    total_cnt++; if (o !== 32'hA5) $display("FAIL fpp_last got=%h exp=a5", o); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL fpp_empty got=%b exp=1", Empty); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit pp; logic [DW-1:0] o, e;
    int n = 0, rx = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (j < 2) begin
          step(1, DW'(32'h100 + n), (j == 0), 0, pp, o, e);
          n++;
        end else begin
          step(0, '0, 1, 0, pp, o, e);
        end
        if (pp) begin
          total_cnt++; if (o !== DW'(32'h100 + rx)) $display("FAIL wrap_order got=%h exp=%h", o, DW'(32'h100 + rx)); else pass_cnt++;
          rx++;
        end
      end
    end
    for (int i = 0; i < 16 && mq.size() > 0; i++) begin
      step(0, '0, 1, 0, pp, o, e);
      if (pp) begin
        total_cnt++; if (o !== DW'(32'h100 + rx)) $display("FAIL wrap_order got=%h exp=%h", o, DW'(32'h100 + rx)); else pass_cnt++;
        rx++;
      end
    end
    total_cnt++; if (rx != 20) $display("FAIL wrap_count got=%0d exp=20", rx); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b0 || Empty !== 1'b1) $display("FAIL wrap_end ovf=%b empty=%b exp 0/1", Overflow, Empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    bit pp; logic [DW-1:0] o, e;
    for (int i = 0; i < 5; i++) step(1, DW'(32'h50 + i), 0, 0, pp, o, e);
    total_cnt++; if (Count !== 4'd5) $display("FAIL rmb_pre_count got=%0d exp=5", Count); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    mq.delete(); movf = 1'b0;
    total_cnt++; if (Count !== 4'd0 || Rsp_valid !== 1'b0) $display("FAIL rmb_clear count=%0d valid=%b exp 0/0", Count, Rsp_valid); else pass_cnt++;
    total_cnt++; if (Rsp_data !== '0 || Empty !== 1'b1) $display("FAIL rmb_data data=%h empty=%b exp 0/1", Rsp_data, Empty); else pass_cnt++;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1, 32'h1234, 0, 0, pp, o, e);
    total_cnt++; if (Count !== 4'd1 || Rsp_data !== 32'h1234) $display("FAIL rmb_push count=%0d data=%h exp 1/1234", Count, Rsp_data); else pass_cnt++;
`ifdef MEM_RSP_PARITY_EN
    total_cnt++; if (Rsp_parity !== 1'b1) $display("FAIL rmb_parity got=%b exp=1", Rsp_parity); else pass_cnt++;
`endif
    step(0, '0, 1, 0, pp, o, e);
    total_cnt++; if (!pp || o !== 32'h1234 || Empty !== 1'b1) $display("FAIL rmb_alone popped=%b got=%h empty=%b exp 1/1234/1", pp, o, Empty); else pass_cnt++;
  endtask

  task automatic test_random();
    bit pp; logic [DW-1:0] o, e;
    bit v, r, c;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      step(v, DW'($urandom), r, c, pp, o, e);
      if (pp) begin
        total_cnt++; if (o !== e) $display("FAIL rnd_word cyc=%0d got=%h exp=%h", i, o, e); else pass_cnt++;
      end
      total_cnt++; if (Count !== 4'(mq.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, Count, mq.size()); else pass_cnt++;
      total_cnt++; if (Overflow !== movf) $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, Overflow, movf); else pass_cnt++;
      total_cnt++; if (Full !== (mq.size() == DEPTH) || Empty !== (mq.size() == 0)) $display("FAIL rnd_flags cyc=%0d full=%b empty=%b size=%0d", i, Full, Empty, mq.size()); else pass_cnt++;
      total_cnt++; if (Rsp_valid !== (mq.size() > 0) || Rsp_data !== ((mq.size() > 0) ? mq[0] : '0)) $display("FAIL rnd_head cyc=%0d valid=%b data=%h", i, Rsp_valid, Rsp_data); else pass_cnt++;
`ifdef MEM_RSP_PARITY_EN
      total_cnt++; if (Rsp_parity !== ((mq.size() > 0) ? ^mq[0] : 1'b0)) $display("FAIL rnd_parity cyc=%0d got=%b", i, Rsp_parity); else pass_cnt++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
